// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage_pkg
// Description : Shared fetch-state encoding, reset constants and PC+4 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        BUF  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] C_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

    // Bit 31 is the kernel-mode flag; only the low 31 bits advance.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        pc_plus4 = {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage_if
// Description : Instruction-memory request/response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_skid_buffer
// Description : One-word holding register for a fetch returned during a stall.
// Revision    : 1.0 - initial release
// ============================================================================
module if_skid_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        valid
);

    logic [31:0] r_data;
    logic        r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= 32'h0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= din;
            r_valid <= 1'b1;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign dout  = r_data;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : PC register, IF/ID register and variable-latency imem fetch.
//               Optional IF_SKID_BUF_EN adds a skid buffer for stalled returns.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              PC_next,
    input  logic                     IFIDFlush,
    input  logic                     stall,
    output logic [31:0]              PC,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              IFID_Instruction,
    output logic [31:0]              IFID_PC_plus_4,
    output logic                     IFID_valid,
    output logic                     fetch_wait
);

    fetch_state_t r_state;
    fetch_state_t w_state_d;

    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;

    logic        w_avail;
    logic        w_accept;
    logic        w_reissue;
    logic        w_buf_hit;
    logic [31:0] w_word;
    logic [31:0] w_pc_d;

`ifdef IF_SKID_BUF_EN
    logic        w_buf_load;
    logic        w_buf_clear;
    logic [31:0] w_buf_data;
    logic        w_buf_valid;

    if_skid_buffer u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (w_buf_load),
        .clear (w_buf_clear),
        .din   (imem.imem_rdata),
        .dout  (w_buf_data),
        .valid (w_buf_valid)
    );

    assign w_buf_hit   = (r_state == BUF) && w_buf_valid;
    assign w_buf_clear = (r_state == BUF) && w_reissue;
    assign w_word      = w_buf_hit ? w_buf_data : imem.imem_rdata;
`else
    assign w_buf_hit = 1'b0;
    assign w_word    = imem.imem_rdata;
`endif

    assign imem.imem_req  = (r_state == REQ) || (r_state == DROP);
    assign imem.imem_addr = r_req_addr;
    assign fetch_wait     = imem.imem_req && !imem.imem_ready;

    assign w_avail  = ((r_state == REQ) && imem.imem_ready) || w_buf_hit;
    assign w_accept = w_avail && !stall && !IFIDFlush;
    // Any new request targets whatever PC will hold after this edge.
    assign w_pc_d   = (IFIDFlush || w_accept) ? PC_next : r_pc;

    always_comb begin
        w_state_d = r_state;
        w_reissue = 1'b0;
`ifdef IF_SKID_BUF_EN
        w_buf_load = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_state_d = REQ;
                w_reissue = 1'b1;
            end
            REQ: begin
                if (imem.imem_ready) begin
                    if (IFIDFlush || !stall) begin
                        w_reissue = 1'b1;
                    end
`ifdef IF_SKID_BUF_EN
                    else begin
                        w_state_d  = BUF;
                        w_buf_load = 1'b1;
                    end
`endif
                end else if (IFIDFlush) begin
                    w_state_d = DROP;
                end
            end
            DROP: begin
                if (imem.imem_ready) begin
                    w_state_d = REQ;
                    w_reissue = 1'b1;
                end
            end
`ifdef IF_SKID_BUF_EN
            BUF: begin
                if (IFIDFlush || !stall) begin
                    w_state_d = REQ;
                    w_reissue = 1'b1;
                end
            end
`endif
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            if (w_reissue) begin
                r_req_addr <= w_pc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (IFIDFlush) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (stall) begin
            r_ifid_instr <= r_ifid_instr;
        end else if (w_accept) begin
            r_ifid_instr <= w_word;
            r_ifid_pc4   <= pc_plus4(r_pc);
            r_ifid_valid <= 1'b1;
        end else begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end
    end

    assign PC               = r_pc;
    assign IFID_Instruction = r_ifid_instr;
    assign IFID_PC_plus_4   = r_ifid_pc4;
    assign IFID_valid       = r_ifid_valid;

endmodule
`default_nettype wire
